// File: rtl/fei4_rx_arbiter.sv
// Round-robin burst arbiter merging NCH first-word-fall-through channel FIFOs into one word stream.
// Define FEI4_RX_ARB_WORD_CNT_EN to add per-channel saturating word counters (WORD_CNT, CNT_CLR).
module fei4_rx_arbiter #(
    parameter int NCH       = 4,
    parameter int MAX_BURST = 16,
    parameter int DWIDTH    = 32,
    localparam int IDW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST,
    input  logic [NCH-1:0]          CH_EN,
    input  logic [NCH-1:0]          FIFO_EMPTY,
    input  logic [NCH*DWIDTH-1:0]   FIFO_DATA,
    output logic [NCH-1:0]          FIFO_READ,
    input  logic                    OUT_FULL,
    output logic                    OUT_WRITE,
    output logic [DWIDTH-1:0]       OUT_DATA,
    output logic                    GRANT_VALID,
    output logic [IDW-1:0]          GRANT_ID
`ifdef FEI4_RX_ARB_WORD_CNT_EN
    ,
    input  logic                    CNT_CLR,
    output logic [NCH*16-1:0]       WORD_CNT
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    state_t                 state;
    state_t                 state_next;
    logic [IDW-1:0]         ptr;
    logic [IDW-1:0]         ptr_next;
    logic [IDW-1:0]         grant_next;
    logic [7:0]             burst_cnt;
    logic [7:0]             burst_cnt_next;
    logic [NCH-1:0]         req;
    logic                   req_granted;
    logic                   rd;
    logic                   found;
    logic [IDW-1:0]         found_id;
    logic [IDW-1:0]         idx;
    logic [DWIDTH-1:0]      ch_word [NCH];

    assign req         = CH_EN & ~FIFO_EMPTY;
    assign req_granted = req[GRANT_ID];
    assign rd          = (state == BURST) && req_granted && !OUT_FULL && (burst_cnt < MAX_CNT);
    assign GRANT_VALID = (state == BURST);

    for (genvar i = 0; i < NCH; i++) begin : g_word
        assign ch_word[i] = FIFO_DATA[i*DWIDTH +: DWIDTH];
    end

    // Scan from farthest to nearest so the channel right after ptr wins; ptr itself comes last.
    always_comb begin
        found    = 1'b0;
        found_id = '0;
        idx      = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NCH);
            if (req[idx]) begin
                found    = 1'b1;
                found_id = idx;
            end
        end
    end

    always_comb begin
        FIFO_READ = '0;
        if (!BUS_RST && rd) begin
            FIFO_READ[GRANT_ID] = 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        grant_next     = GRANT_ID;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (found && !OUT_FULL) begin
                    state_next     = BURST;
                    grant_next     = found_id;
                    burst_cnt_next = '0;
                end
            end
            BURST: begin
                if (rd) begin
                    burst_cnt_next = burst_cnt + 8'd1;
                end
                // Handing ptr the served channel makes it the last one searched next time.
                if (!req_granted || (burst_cnt == MAX_CNT)) begin
                    state_next = IDLE;
                    ptr_next   = GRANT_ID;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= IDLE;
            ptr       <= IDW'(NCH - 1);
            GRANT_ID  <= '0;
            burst_cnt <= '0;
            OUT_WRITE <= 1'b0;
            OUT_DATA  <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            GRANT_ID  <= grant_next;
            burst_cnt <= burst_cnt_next;
            OUT_WRITE <= rd;
            if (rd) begin
                OUT_DATA <= ch_word[GRANT_ID];
            end
        end
    end

`ifdef FEI4_RX_ARB_WORD_CNT_EN
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || CNT_CLR) begin
            WORD_CNT <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (FIFO_READ[i] && (WORD_CNT[i*16 +: 16] != 16'hFFFF)) begin
                    WORD_CNT[i*16 +: 16] <= WORD_CNT[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
